// File: rtl/budget_pkg.sv
// Shared types and constants for the latency-budget watchdog.
package budget_pkg;

  // Default widths matching the monitor's standard configuration.
  localparam int unsigned DefAccuWidth = 12;
  localparam int unsigned DefLenWidth  = 8;

  // Fixed per-transaction overhead added on top of the AXI len field.
  localparam int unsigned BudgetOverhead = 5;

  typedef logic [DefAccuWidth-1:0] accu_cnt_t;
  typedef logic [DefLenWidth-1:0]  len_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    TIMEOUT = 2'd2
  } budget_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and enable.
module sat_counter #(
  parameter int unsigned Width = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q;
  logic [Width-1:0] cnt_d;

  // Clear wins over enable; count holds once it reaches all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/budget_watchdog.sv
// Latency-budget watchdog: accumulates per-transaction budget on issue,
// releases it on retire, and flags a sticky timeout when no retire lands
// within the accumulated budget.
module budget_watchdog
  import budget_pkg::*;
#(
  parameter int unsigned MaxTxns   = 8,
  parameter int unsigned LenWidth  = 8,
  parameter int unsigned AccuWidth = 12
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         issue_valid_i,
  output logic                         issue_ready_o,
  input  logic [LenWidth-1:0]          issue_len_i,
  input  logic                         retire_valid_i,
  input  logic [LenWidth-1:0]          retire_len_i,
  input  logic                         clear_i,
  output logic [AccuWidth-1:0]         budget_o,
  output logic [$clog2(MaxTxns+1)-1:0] outstanding_o,
  output logic [AccuWidth-1:0]         elapsed_o,
  output logic                         timeout_o,
  output logic                         err_o
);

  localparam int unsigned CntWidth = $clog2(MaxTxns + 1);

  budget_state_e        state_q, state_d;
  logic [AccuWidth-1:0] budget_q, budget_d;
  logic [CntWidth-1:0]  count_q, count_d;
  logic                 err_q, err_d;

  logic                 issue_hs;
  logic                 retire_ok;
  logic [AccuWidth-1:0] issue_cost;
  logic [AccuWidth-1:0] retire_cost;
  logic [AccuWidth-1:0] elapsed;
  logic                 elapsed_clr;
  logic                 elapsed_en;

  // Issue is accepted while there is room and no timeout is pending.
  always_comb begin
    issue_ready_o = (count_q < CntWidth'(MaxTxns)) && (state_q != TIMEOUT);
  end

  // Budget and outstanding-count bookkeeping; a retire with nothing
  // outstanding is dropped and reported.
  always_comb begin
    issue_hs    = issue_valid_i && issue_ready_o;
    retire_ok   = retire_valid_i && (count_q != '0);
    err_d       = retire_valid_i && (count_q == '0);
    issue_cost  = AccuWidth'(issue_len_i) + AccuWidth'(BudgetOverhead);
    retire_cost = AccuWidth'(retire_len_i) + AccuWidth'(BudgetOverhead);
    budget_d    = budget_q;
    count_d     = count_q;
    if (issue_hs) begin
      budget_d = budget_d + issue_cost;
    end
    if (retire_ok) begin
      budget_d = budget_d - retire_cost;
    end
    if (issue_hs && !retire_ok) begin
      count_d = count_q + CntWidth'(1);
    end else if (retire_ok && !issue_hs) begin
      count_d = count_q - CntWidth'(1);
    end
  end

  // Next-state and elapsed-counter control; a retire beats a timeout.
  always_comb begin
    state_d     = state_q;
    elapsed_clr = 1'b0;
    elapsed_en  = 1'b0;
    case (state_q)
      IDLE: begin
        elapsed_clr = 1'b1;
        if (issue_hs) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (retire_ok) begin
          elapsed_clr = 1'b1;
          if (count_d == '0) begin
            state_d = IDLE;
          end
        end else begin
          elapsed_en = 1'b1;
          if (elapsed >= budget_q) begin
            state_d = TIMEOUT;
          end
        end
      end
      TIMEOUT: begin
        if (clear_i) begin
          elapsed_clr = 1'b1;
          state_d     = (count_d == '0) ? IDLE : ACTIVE;
        end
      end
      default: begin
        elapsed_clr = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // State, budget, count and error-pulse registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      budget_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      budget_q <= budget_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  sat_counter #(
    .Width (AccuWidth)
  ) u_elapsed (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (elapsed_clr),
    .en_i  (elapsed_en),
    .cnt_o (elapsed)
  );

  assign budget_o      = budget_q;
  assign outstanding_o = count_q;
  assign elapsed_o     = elapsed;
  assign timeout_o     = (state_q == TIMEOUT);
  assign err_o         = err_q;

endmodule

// File: tb/tb_budget_watchdog.sv
// Directed and randomized bench for budget_watchdog against a transaction-level model.
module tb_budget_watchdog;
  import budget_pkg::*;

  localparam int unsigned MaxTxns   = 8;
  localparam int unsigned LenWidth  = 8;
  localparam int unsigned AccuWidth = 12;
  localparam int unsigned CntWidth  = $clog2(MaxTxns + 1);
  localparam int unsigned AccuMax   = (1 << AccuWidth) - 1;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  logic                 issue_valid_i = 1'b0;
  logic                 issue_ready_o;
  logic [LenWidth-1:0]  issue_len_i = '0;
  logic                 retire_valid_i = 1'b0;
  logic [LenWidth-1:0]  retire_len_i = '0;
  logic                 clear_i = 1'b0;
  logic [AccuWidth-1:0] budget_o;
  logic [CntWidth-1:0]  outstanding_o;
  logic [AccuWidth-1:0] elapsed_o;
  logic                 timeout_o;
  logic                 err_o;

  budget_watchdog #(
    .MaxTxns   (MaxTxns),
    .LenWidth  (LenWidth),
    .AccuWidth (AccuWidth)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .issue_valid_i  (issue_valid_i),
    .issue_ready_o  (issue_ready_o),
    .issue_len_i    (issue_len_i),
    .retire_valid_i (retire_valid_i),
    .retire_len_i   (retire_len_i),
    .clear_i        (clear_i),
    .budget_o       (budget_o),
    .outstanding_o  (outstanding_o),
    .elapsed_o      (elapsed_o),
    .timeout_o      (timeout_o),
    .err_o          (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: outstanding transactions as a queue of lens, budget as
  // a running sum, a sticky timeout bit and a saturating elapsed count.
  int unsigned m_budget  = 0;
  int unsigned m_elapsed = 0;
  bit          m_to      = 1'b0;
  bit          m_err     = 1'b0;
  int unsigned q_lens[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check_eq("budget", 32'(budget_o), m_budget);
    check_eq("outstanding", 32'(outstanding_o), q_lens.size());
    check_eq("elapsed", 32'(elapsed_o), m_elapsed);
    check_eq("timeout", 32'(timeout_o), 32'(m_to));
    check_eq("err", 32'(err_o), 32'(m_err));
    check_eq("ready", 32'(issue_ready_o), 32'((q_lens.size() < MaxTxns) && !m_to));
  endtask

  // Drive one cycle of inputs (called at a falling edge), advance the model,
  // then check every output at the next falling edge.
  task automatic step(input bit rst, input bit iv, input int unsigned ilen,
                      input bit rv, input int unsigned rlen, input bit clr);
    bit          ready, hs, rok, to_n;
    int unsigned el_n;
    rst_i          = rst;
    issue_valid_i  = iv;
    issue_len_i    = LenWidth'(ilen);
    retire_valid_i = rv;
    retire_len_i   = LenWidth'(rlen);
    clear_i        = clr;
    if (rst) begin
      q_lens.delete();
      m_budget  = 0;
      m_elapsed = 0;
      m_to      = 1'b0;
      m_err     = 1'b0;
    end else begin
      ready = (q_lens.size() < MaxTxns) && !m_to;
      hs    = iv && ready;
      rok   = rv && (q_lens.size() > 0);
      to_n  = m_to;
      el_n  = m_elapsed;
      if (m_to) begin
        if (clr) begin
          to_n = 1'b0;
          el_n = 0;
        end
      end else if (q_lens.size() == 0) begin
        el_n = 0;
      end else if (rok) begin
        el_n = 0;
      end else begin
        if (m_elapsed >= m_budget) to_n = 1'b1;
        el_n = (m_elapsed >= AccuMax) ? AccuMax : m_elapsed + 1;
      end
      if (hs) m_budget = m_budget + (ilen % 256) + BudgetOverhead;
      if (rok) m_budget = m_budget - ((rlen % 256) + BudgetOverhead);
      m_budget = m_budget & AccuMax;
      if (rok) void'(q_lens.pop_front());
      if (hs) q_lens.push_back(ilen % 256);
      m_err     = rv && !rok;
      m_to      = to_n;
      m_elapsed = el_n;
    end
    @(posedge clk_i);
    @(negedge clk_i);
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int unsigned rv_pct;
    int unsigned ilen;
    int unsigned rlen;
    @(negedge clk_i);

    // Reset values, then single issue len=3 runs out its budget.
    do_reset();
    check_eq("rst_budget", 32'(budget_o), 0);
    check_eq("rst_outstanding", 32'(outstanding_o), 0);
    check_eq("rst_elapsed", 32'(elapsed_o), 0);
    check_eq("rst_timeout", 32'(timeout_o), 0);
    check_eq("rst_err", 32'(err_o), 0);
    check_eq("rst_ready", 32'(issue_ready_o), 1);
    step(0, 1, 3, 0, 0, 0);
    check_eq("t1_budget", 32'(budget_o), 8);
    check_eq("t1_outstanding", 32'(outstanding_o), 1);
    check_eq("t1_elapsed", 32'(elapsed_o), 0);
    idle(8);
    check_eq("t1_elapsed_c9", 32'(elapsed_o), 8);
    check_eq("t1_no_timeout_c9", 32'(timeout_o), 0);
    idle(1);
    check_eq("t1_timeout_c10", 32'(timeout_o), 1);
    check_eq("t1_ready_c10", 32'(issue_ready_o), 0);
    idle(3);
    check_eq("t1_timeout_sticky", 32'(timeout_o), 1);
    // Retire inside TIMEOUT, then clear: back to IDLE with empty budget.
    step(0, 0, 0, 1, 3, 0);
    check_eq("t6_still_timeout", 32'(timeout_o), 1);
    step(0, 0, 0, 0, 0, 1);
    check_eq("t6_timeout_cleared", 32'(timeout_o), 0);
    check_eq("t6_budget", 32'(budget_o), 0);
    check_eq("t6_ready", 32'(issue_ready_o), 1);

    // Back-to-back issues then a retire at cycle 6.
    do_reset();
    step(0, 1, 3, 0, 0, 0);
    check_eq("t2_budget_8", 32'(budget_o), 8);
    step(0, 1, 7, 0, 0, 0);
    check_eq("t2_budget_20", 32'(budget_o), 20);
    idle(4);
    step(0, 0, 0, 1, 3, 0);
    check_eq("t2_budget_12", 32'(budget_o), 12);
    check_eq("t2_elapsed_0", 32'(elapsed_o), 0);
    check_eq("t2_no_timeout", 32'(timeout_o), 0);

    // Fill to capacity with len=0, then a lone retire reopens issue.
    do_reset();
    for (int i = 0; i < int'(MaxTxns); i++) step(0, 1, 0, 0, 0, 0);
    check_eq("t3_ready_full", 32'(issue_ready_o), 0);
    check_eq("t3_budget_40", 32'(budget_o), 40);
    step(0, 1, 0, 0, 0, 0);
    check_eq("t3_blocked_count", 32'(outstanding_o), 8);
    step(0, 0, 0, 1, 0, 0);
    check_eq("t3_ready_again", 32'(issue_ready_o), 1);
    check_eq("t3_budget_35", 32'(budget_o), 35);

    // Simultaneous issue and retire with one outstanding.
    do_reset();
    step(0, 1, 2, 0, 0, 0);
    idle(2);
    step(0, 1, 10, 1, 2, 0);
    check_eq("t4_count", 32'(outstanding_o), 1);
    check_eq("t4_budget", 32'(budget_o), 15);
    check_eq("t4_elapsed", 32'(elapsed_o), 0);

    // Retire with nothing outstanding.
    do_reset();
    step(0, 0, 0, 1, 4, 0);
    check_eq("t5_err_pulse", 32'(err_o), 1);
    check_eq("t5_budget", 32'(budget_o), 0);
    check_eq("t5_count", 32'(outstanding_o), 0);
    idle(1);
    check_eq("t5_err_drop", 32'(err_o), 0);

    // Reset mid-ACTIVE.
    do_reset();
    step(0, 1, 5, 0, 0, 0);
    idle(2);
    step(1, 0, 0, 0, 0, 0);
    check_eq("t7_budget", 32'(budget_o), 0);
    check_eq("t7_count", 32'(outstanding_o), 0);
    check_eq("t7_elapsed", 32'(elapsed_o), 0);
    check_eq("t7_ready", 32'(issue_ready_o), 1);

    // Randomized traffic with phases of different retire pressure.
    for (int i = 0; i < 3000; i++) begin
      case ((i / 500) % 6)
        0: rv_pct = 30;
        1: rv_pct = 5;
        2: rv_pct = 60;
        3: rv_pct = 15;
        4: rv_pct = 0;
        default: rv_pct = 40;
      endcase
      ilen = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 11);
      rlen = (q_lens.size() > 0) ? q_lens[0] : $urandom_range(0, 255);
      step(($urandom_range(0, 399) == 0),
           bit'($urandom_range(0, 1)),
           ilen,
           ($urandom_range(0, 99) < rv_pct),
           rlen,
           ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
